// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the geometry (line count, words per line, address field widths)
// and the controller state encoding used by dcache and dcache_array.
package dcache_pkg;

  localparam int LINE_NUM   = 64;  // direct-mapped lines
  localparam int LINE_WORDS = 4;   // 32-bit words per line
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 6;   // cpu_addr[9:4]
  localparam int WORD_W     = 2;   // cpu_addr[3:2]
  localparam int TAG_W      = 22;  // cpu_addr[31:10]
  localparam int LINE_W     = LINE_WORDS * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // serving hits, detecting misses
    S_BACK = 2'd1,  // writing the dirty victim line back to memory
    S_FILL = 2'd2   // reading the missed line from memory
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Storage for the data cache: per-line valid, dirty, tag and data words.
// Reads are combinational on 'index'; word and tag writes happen at posedge.
// Ports:
//   clk, rst          clock and synchronous active-high reset (clears valid/dirty)
//   index             line selected for both read and write
//   rd_valid/rd_dirty/rd_tag/rd_line  combinational view of the selected line
//   word_we, word_sel, word_din       write one data word of the selected line
//   set_dirty         with word_we: mark the line dirty (CPU store)
//   tag_we, tag_din   install a new tag, line becomes valid and clean
module dcache_array
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_we,
  input  logic [WORD_W-1:0] word_sel,
  input  logic [DATA_W-1:0] word_din,
  input  logic              set_dirty,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  tag_din
);

  logic [LINE_NUM-1:0] valid_q;
  logic [LINE_NUM-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
  logic [DATA_W-1:0]   data_mem [LINE_NUM][LINE_WORDS];

  always_comb begin
    rd_valid = valid_q[index];
    rd_dirty = dirty_q[index];
    rd_tag   = tag_mem[index];
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_line[w*DATA_W +: DATA_W] = data_mem[index][w];
    end
  end

  // A tag install always ends a fill, so it wins and leaves the line clean.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (word_we && set_dirty) dirty_q[index] <= 1'b1;
      if (tag_we) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid bits gate
  // every use, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (word_we) data_mem[index][word_sel] <= word_din;
    if (tag_we)  tag_mem[index]            <= tag_din;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache for a MEM stage.
// Hits complete with zero latency; misses stall the pipeline while the
// controller writes back a dirty victim (S_BACK) and refills the line (S_FILL)
// one word per mem_ack. The stalled request is re-presented and then hits.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_ren, cpu_wen              load / store request (store wins)
//   cpu_addr, cpu_din             byte address and store data
//   cpu_dout, cpu_stall           load data on read hit (else 0), stall
//   mem_cs, mem_we, mem_addr      memory request, direction, word address
//   mem_dout, mem_din, mem_ack    write-back data, fill data, word handshake
module dcache
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]  lat_idx_q, lat_idx_d;

  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [WORD_W-1:0] cpu_word;
  logic              unused_byte_bits;

  logic [IDX_W-1:0]  arr_idx;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              word_we, set_dirty, tag_we;
  logic [WORD_W-1:0] word_sel;
  logic [DATA_W-1:0] word_din;

  logic req, hit;

  assign cpu_tag          = cpu_addr[31:10];
  assign cpu_idx          = cpu_addr[9:4];
  assign cpu_word         = cpu_addr[3:2];
  assign unused_byte_bits = ^cpu_addr[1:0];  // word access only

  // While transferring, the array must keep pointing at the missed line even
  // if the pipeline changes cpu_addr.
  assign arr_idx = (state_q == S_IDLE) ? cpu_idx : lat_idx_q;

  assign req = cpu_ren | cpu_wen;
  assign hit = req && rd_valid && (rd_tag == cpu_tag) && (state_q == S_IDLE);

  dcache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (arr_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_din  (word_din),
    .set_dirty (set_dirty),
    .tag_we    (tag_we),
    .tag_din   (lat_tag_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_tag_q <= lat_tag_d;
      lat_idx_q <= lat_idx_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_tag_d = lat_tag_q;
    lat_idx_d = lat_idx_q;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    word_we   = 1'b0;
    set_dirty = 1'b0;
    word_sel  = cpu_word;
    word_din  = cpu_din;
    tag_we    = 1'b0;
    cpu_dout  = '0;
    cpu_stall = (state_q != S_IDLE) || (req && !hit);

    if (hit && cpu_ren && !cpu_wen) cpu_dout = rd_line[{cpu_word, 5'd0} +: DATA_W];

    case (state_q)
      S_IDLE: begin
        if (hit && cpu_wen) begin
          word_we   = 1'b1;
          set_dirty = 1'b1;
        end else if (req && !hit) begin
          lat_tag_d = cpu_tag;
          lat_idx_d = cpu_idx;
          cnt_d     = '0;
          state_d   = (rd_valid && rd_dirty) ? S_BACK : S_FILL;
        end
      end
      // The victim tag is still in the array until the fill completes.
      S_BACK: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {rd_tag, lat_idx_q, cnt_q, 2'b00};
        mem_dout = rd_line[{cnt_q, 5'd0} +: DATA_W];
        if (mem_ack) begin
          cnt_d = cnt_q + 2'd1;  // 3 -> 0 on the last word
          if (cnt_q == 2'd3) state_d = S_FILL;
        end
      end
      S_FILL: begin
        mem_cs   = 1'b1;
        mem_addr = {lat_tag_q, lat_idx_q, cnt_q, 2'b00};
        if (mem_ack) begin
          word_we  = 1'b1;
          word_sel = cnt_q;
          word_din = mem_din;
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tag_we  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache. A memory responder acks each word after
// ack_delay idle cycles and checks every transfer against a scoreboard of
// expected memory transactions pushed by the stimulus.
module tb_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ren, cpu_wen;
  logic [31:0] cpu_addr, cpu_din;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;

  dcache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_stall (cpu_stall),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          tests    = 0;
  int          failures = 0;
  int          ack_delay = 0;
  int          ack_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: acts on the falling edge, ack held across one posedge.
  initial begin : responder
    int          wait_n = 0;
    logic [31:0] held_addr;
    logic        held_we;
    txn_t        t;
    mem_ack = 1'b0;
    mem_din = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_cs) begin
        if (wait_n == 0) begin
          held_addr = mem_addr;
          held_we   = mem_we;
        end else begin
          check("mem_addr_stable", mem_addr, held_addr);
          check("mem_we_stable", {31'd0, mem_we}, {31'd0, held_we});
        end
        if (wait_n >= ack_delay) begin
          if (exp_q.size() == 0) begin
            check("unexpected_mem_txn", mem_addr, 32'hFFFF_FFFF);
          end else begin
            t = exp_q.pop_front();
            check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
            check("mem_addr", mem_addr, t.addr);
            if (t.we) check("mem_dout", mem_dout, t.data);
          end
          if (mem_we) mem_model[mem_addr] = mem_dout;
          else        mem_din = model_rd(mem_addr);
          mem_ack = 1'b1;
          ack_cnt++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
      end
    end
  end

  task automatic push_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, base + 32'(4*i), 32'd0});
  endtask

  task automatic push_wb(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    exp_q.push_back('{1'b1, base,          d0});
    exp_q.push_back('{1'b1, base + 32'd4,  d1});
    exp_q.push_back('{1'b1, base + 32'd8,  d2});
    exp_q.push_back('{1'b1, base + 32'd12, d3});
  endtask

  // One CPU access held until stall drops. Inputs change at negedge+1,
  // outputs are sampled at negedge+3. exp_xfer is the number of cycles with
  // mem_cs high (4 per line moved with single-cycle ack).
  task automatic access(input string tag, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] exp_dout, input int exp_xfer);
    int n    = 0;
    int xfer = 0;
    @(negedge clk); #1;
    cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_din = din;
    #2;
    check({tag, "_stall_first"}, {31'd0, cpu_stall}, {31'd0, (exp_xfer != 0)});
    while (cpu_stall && n < 400) begin
      @(negedge clk); #3;
      if (mem_cs) xfer++;
      n++;
    end
    check({tag, "_stall_bound"}, {31'd0, cpu_stall}, 32'd0);
    check({tag, "_xfer_cycles"}, xfer, exp_xfer);
    check({tag, "_mem_cs_hit"}, {31'd0, mem_cs}, 32'd0);
    if (ren && !wen) check({tag, "_dout"}, cpu_dout, exp_dout);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    @(negedge clk); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    rst = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_din = '0;
    mem_model[32'h40]  = 32'h11; mem_model[32'h44]  = 32'h22;
    mem_model[32'h48]  = 32'h33; mem_model[32'h4C]  = 32'h44;
    mem_model[32'h440] = 32'h55; mem_model[32'h444] = 32'h66;
    mem_model[32'h448] = 32'h77; mem_model[32'h44C] = 32'h88;
    mem_model[32'h80]  = 32'h91; mem_model[32'h84]  = 32'h92;
    mem_model[32'h88]  = 32'h93; mem_model[32'h8C]  = 32'h94;
    mem_model[32'h480] = 32'hB1; mem_model[32'h100] = 32'hA1;
    mem_model[32'h104] = 32'hA2; mem_model[32'h108] = 32'hA3;
    mem_model[32'h10C] = 32'hA4;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    #2;
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_dout", cpu_dout, 32'd0);
    check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_dout", mem_dout, 32'd0);

    // Cold load miss, then zero-latency hit in the same line.
    push_fill(32'h40);
    access("load40_miss", 1'b1, 1'b0, 32'h40, '0, 32'h11, 4);
    access("load44_hit", 1'b1, 1'b0, 32'h44, '0, 32'h22, 0);
    access("load4e_hit", 1'b1, 1'b0, 32'h4E, '0, 32'h44, 0);  // byte bits ignored

    // Store hit makes the line dirty; a conflicting load writes it back first.
    access("store40_hit", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, '0, 0);
    access("store_wins", 1'b1, 1'b1, 32'h48, 32'h0BAD_0033, '0, 0);
    push_wb(32'h40, 32'hDEADBEEF, 32'h22, 32'h0BAD_0033, 32'h44);
    push_fill(32'h440);
    access("load440_dirty", 1'b1, 1'b0, 32'h440, '0, 32'h55, 8);

    // Clean store miss allocates, then the store lands and dirties the line.
    push_fill(32'h80);
    access("store80_miss", 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, '0, 4);
    access("load80_hit", 1'b1, 1'b0, 32'h80, '0, 32'hCAFEF00D, 0);
    access("load84_hit", 1'b1, 1'b0, 32'h84, '0, 32'h92, 0);
    push_wb(32'h80, 32'hCAFEF00D, 32'h92, 32'h93, 32'h94);
    push_fill(32'h480);
    access("load480_dirty", 1'b1, 1'b0, 32'h480, '0, 32'hB1, 8);

    // Slow memory: each word waits 3 extra cycles.
    ack_delay = 3;
    push_fill(32'h100);
    access("load108_slow", 1'b1, 1'b0, 32'h108, '0, 32'hA3, 16);
    ack_delay = 0;

    // Idle with no request.
    @(negedge clk); #3;
    check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    check("idle_mem_cs", {31'd0, mem_cs}, 32'd0);

    // Reset on the second fill ack aborts the transfer.
    push_fill(32'h40);
    n = ack_cnt;
    @(negedge clk); #1;
    cpu_ren = 1'b1; cpu_addr = 32'h40;
    for (int i = 0; i < 50 && ack_cnt != n + 2; i++) begin
      @(negedge clk); #1;
    end
    check("abort_ack_reached", ack_cnt, n + 2);
    rst = 1'b1; cpu_ren = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    #2;
    check("abort_mem_cs", {31'd0, mem_cs}, 32'd0);
    check("abort_stall", {31'd0, cpu_stall}, 32'd0);
    exp_q.delete();
    push_fill(32'h40);
    access("reload40_miss", 1'b1, 1'b0, 32'h40, '0, 32'hDEADBEEF, 4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
